// File: rtl/poly_arith_pkg.sv
// ---------------------------------------------------------------------------
// poly_arith_pkg
//   Shared types and constants for the polynomial arithmetic unit.
//
//   COEFF_W     : default coefficient width in bits.
//   Q_MOD       : default coefficient modulus.
//   coeff_t     : one coefficient (COEFF_W bits).
//   addsub_op_e : operation select for the modular add/sub pipeline.
//                 ADD    -> (a + b)  mod Q
//                 SUB    -> (a - b)  mod Q
//                 PASS_A -> a
//                 NEG_B  -> (-b)     mod Q
// ---------------------------------------------------------------------------
package poly_arith_pkg;

    localparam int COEFF_W = 12;
    localparam int Q_MOD   = 3329;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        PASS_A = 2'd2,
        NEG_B  = 2'd3
    } addsub_op_e;

    // Operand A participates in every op except NEG_B.
    function automatic logic op_uses_a(input addsub_op_e op);
        return (op != NEG_B);
    endfunction

    // Operand B participates in every op except PASS_A.
    function automatic logic op_uses_b(input addsub_op_e op);
        return (op != PASS_A);
    endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// ---------------------------------------------------------------------------
// mod_addsub_lane
//   Combinational first half of one modular add/sub lane. Produces the
//   unreduced result (WIDTH+1 bits) and an out-of-range flag for the
//   operands the selected op actually uses.
//
//   Ports:
//     i_op        : operation select (addsub_op_e).
//     i_a, i_b    : lane operands, expected in [0, Q-1].
//     o_raw       : unreduced result; <= 2Q-1 whenever the operands are in
//                   range, so a single conditional subtract of Q reduces it.
//     o_range_err : a used operand is >= Q.
// ---------------------------------------------------------------------------
module mod_addsub_lane
    import poly_arith_pkg::*;
#(
    parameter int WIDTH = COEFF_W,
    parameter int Q     = Q_MOD
) (
    input  addsub_op_e       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_raw,
    output logic             o_range_err
);

    localparam logic [WIDTH:0] LP_Q = (WIDTH+1)'(Q);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic           w_a_bad;
    logic           w_b_bad;

    assign w_a_ext = {1'b0, i_a};
    assign w_b_ext = {1'b0, i_b};
    assign w_a_bad = (w_a_ext >= LP_Q);
    assign w_b_bad = (w_b_ext >= LP_Q);

    // Subtraction is expressed as addition of (Q - b) so every op yields a
    // non-negative value in [0, 2Q-1]. With b = 0 this gives a + Q (SUB) or
    // Q (NEG_B), both of which the reduction stage folds back to a and 0.
    always_comb begin
        o_raw = '0;
        unique case (i_op)
            ADD:     o_raw = w_a_ext + w_b_ext;
            SUB:     o_raw = w_a_ext + (LP_Q - w_b_ext);
            PASS_A:  o_raw = w_a_ext;
            NEG_B:   o_raw = LP_Q - w_b_ext;
            default: o_raw = '0;
        endcase
    end

    // Only operands the op consumes can raise the flag.
    assign o_range_err = (op_uses_a(i_op) && w_a_bad) ||
                         (op_uses_b(i_op) && w_b_bad);

endmodule

// File: rtl/mod_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// mod_add_sub_pipe
//   Multi-lane, two-stage pipelined modular adder/subtractor placed between
//   the coefficient memory read path and the NTT/butterfly datapath.
//
//   Stage 1 registers the per-lane raw sum and range flag computed by
//   mod_addsub_lane. Stage 2 registers the reduced result. Both stages carry
//   the sideband tag. Capacity is two beats, throughput one beat per cycle.
//
//   Handshake (both interfaces):
//     A beat transfers on a rising edge where valid and ready are both 1.
//     The producer holds valid and data stable until the transfer; the
//     output beat (result_o, tag_o, range_err_o) is held while
//     out_valid_o=1 and out_ready_i=0. in_ready_o depends combinationally
//     on out_ready_i so a full pipe can accept and deliver in one cycle.
//
//   Ports:
//     clk, rst     : clock (rising edge), asynchronous active-high reset.
//     in_valid_i   : input beat valid.       in_ready_o  : input accepted.
//     op_i         : 0=ADD 1=SUB 2=PASS_A 3=NEG_B, captured at acceptance.
//     op1_i, op2_i : lane k at bits [k*WIDTH +: WIDTH].
//     tag_i        : sideband tag, passed through unchanged.
//     out_valid_o  : output beat valid.      out_ready_i : downstream ready.
//     result_o     : per-lane result in [0, Q-1] (0 for a flagged lane).
//     tag_o        : tag of the output beat.
//     range_err_o  : per-lane flag, a used operand was >= Q.
// ---------------------------------------------------------------------------
module mod_add_sub_pipe
    import poly_arith_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = COEFF_W,
    parameter int Q         = Q_MOD,
    parameter int TAG_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0]                 op_i,
    input  logic [NUM_LANES*WIDTH-1:0] op1_i,
    input  logic [NUM_LANES*WIDTH-1:0] op2_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_LANES*WIDTH-1:0] result_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic [NUM_LANES-1:0]       range_err_o
);

    localparam logic [WIDTH:0] LP_Q = (WIDTH+1)'(Q);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                             r_s1_valid;
    logic [NUM_LANES-1:0][WIDTH:0]    r_s1_raw;
    logic [NUM_LANES-1:0]             r_s1_err;
    logic [TAG_W-1:0]                 r_s1_tag;

    logic                             r_s2_valid;
    logic [NUM_LANES*WIDTH-1:0]       r_s2_result;
    logic [NUM_LANES-1:0]             r_s2_err;
    logic [TAG_W-1:0]                 r_s2_tag;

    // ------------------------------------------------------------------
    // Combinational datapath and control
    // ------------------------------------------------------------------
    addsub_op_e                       w_op;
    logic [NUM_LANES-1:0][WIDTH:0]    w_lane_raw;
    logic [NUM_LANES-1:0]             w_lane_err;
    logic [NUM_LANES*WIDTH-1:0]       w_reduced;
    logic                             w_s1_load;
    logic                             w_s2_load;

    assign w_op = addsub_op_e'(op_i);

    // Stage 2 takes the stage-1 beat when it is empty or its beat leaves now.
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready_i);
    // Stage 1 has room when empty or when its beat moves forward this cycle.
    assign in_ready_o = !r_s1_valid || w_s2_load;
    assign w_s1_load  = in_valid_i && in_ready_o;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mod_addsub_lane #(
                .WIDTH (WIDTH),
                .Q     (Q)
            ) u_lane (
                .i_op        (w_op),
                .i_a         (op1_i[g*WIDTH +: WIDTH]),
                .i_b         (op2_i[g*WIDTH +: WIDTH]),
                .o_raw       (w_lane_raw[g]),
                .o_range_err (w_lane_err[g])
            );

            // Single conditional subtract; a flagged lane is forced to 0 so
            // garbage from out-of-range operands never reaches the datapath.
            assign w_reduced[g*WIDTH +: WIDTH] =
                r_s1_err[g]             ? '0 :
                (r_s1_raw[g] >= LP_Q)   ? WIDTH'(r_s1_raw[g] - LP_Q) :
                                          r_s1_raw[g][WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: raw sums, range flags, tag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_err   <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_raw   <= w_lane_raw;
                r_s1_err   <= w_lane_err;
                r_s1_tag   <= tag_i;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduced results, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_err    <= '0;
            r_s2_tag    <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= w_reduced;
                r_s2_err    <= r_s1_err;
                r_s2_tag    <= r_s1_tag;
            end else if (out_ready_i) begin
                r_s2_valid  <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign result_o    = r_s2_result;
    assign range_err_o = r_s2_err;
    assign tag_o       = r_s2_tag;

endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_mod_add_sub_pipe
//   Self-checking bench for mod_add_sub_pipe (4 lanes, 12-bit, Q=3329).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_mod_add_sub_pipe;

    localparam int NL = 4;
    localparam int W  = 12;
    localparam int QV = 3329;
    localparam int TW = 8;
    localparam int BW = NL * W;
    localparam int EW = TW + NL + BW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op_in = 2'd0;
    logic [BW-1:0] op1 = '0;
    logic [BW-1:0] op2 = '0;
    logic [TW-1:0] tag_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] result;
    logic [TW-1:0] tag_o;
    logic [NL-1:0] range_err;

    always #5 clk = ~clk;

    mod_add_sub_pipe #(
        .NUM_LANES (NL),
        .WIDTH     (W),
        .Q         (QV),
        .TAG_W     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op_in),
        .op1_i       (op1),
        .op2_i       (op2),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_o),
        .range_err_o (range_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_v;
    int n_cmp = 0;
    int n_err = 0;
    int n_in  = 0;
    int n_out = 0;

    // Reference model: arithmetic straight from the modular definitions.
    function automatic logic [EW-1:0] model_beat(input logic [1:0] op,
                                                 input logic [BW-1:0] a,
                                                 input logic [BW-1:0] b,
                                                 input logic [TW-1:0] tag);
        logic [BW-1:0] res;
        logic [NL-1:0] err;
        res = '0;
        err = '0;
        for (int k = 0; k < NL; k++) begin
            int ai;
            int bi;
            int r;
            ai = int'(a[k*W +: W]);
            bi = int'(b[k*W +: W]);
            case (op)
                2'd0:    r = (ai + bi) % QV;
                2'd1:    r = (ai + QV - bi) % QV;
                2'd2:    r = ai;
                default: r = (QV - bi) % QV;
            endcase
            if (((op != 2'd3) && ai >= QV) || ((op != 2'd2) && bi >= QV)) begin
                err[k] = 1'b1;
                r = 0;
            end
            res[k*W +: W] = W'(r);
        end
        return {tag, err, res};
    endfunction

    function automatic logic [BW-1:0] pack4(input int x0, input int x1,
                                            input int x2, input int x3);
        return {W'(x3), W'(x2), W'(x1), W'(x0)};
    endfunction

    function automatic logic [BW-1:0] rand_opnd();
        logic [BW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*W +: W] = W'($urandom_range(0, QV-1));
        return v;
    endfunction

    // Monitor: every delivered beat is checked against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: delivered tag %0h, required no beat", tag_o);
            end else begin
                exp_v = exp_q.pop_front();
                if ({tag_o, range_err, result} !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_beat: got tag=%0h err=%b res=%h, required tag=%0h err=%b res=%h",
                             tag_o, range_err, result,
                             exp_v[EW-1 -: TW], exp_v[BW +: NL], exp_v[BW-1:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at posedge+1, return at posedge+1)
    // ------------------------------------------------------------------
    task automatic send_beat(input logic [1:0] op, input logic [BW-1:0] a,
                             input logic [BW-1:0] b, input logic [TW-1:0] tag);
        int  waited;
        bit  done;
        waited = 0;
        done   = 0;
        in_valid = 1'b1;
        op_in    = op;
        op1      = a;
        op2      = b;
        tag_in   = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model_beat(op, a, b, tag));
                n_in++;
                done = 1;
            end else if (waited >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", waited);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        op_in    = 2'($urandom_range(0, 3));
        tag_in   = TW'($urandom_range(0, 255));
    endtask

    // Sends one beat into an empty pipe and reports what comes out and when.
    task automatic send_and_capture(input logic [1:0] op, input logic [BW-1:0] a,
                                    input logic [BW-1:0] b, input logic [TW-1:0] tag,
                                    output logic [BW-1:0] res, output logic [NL-1:0] err,
                                    output logic [TW-1:0] tg, output int lat);
        send_beat(op, a, b, tag);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        res = result;
        err = range_err;
        tg  = tag_o;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        n_cmp++;
        if ({result, tag_o, range_err} !== '0) begin
            n_err++;
            $display("FAIL reset_data: res=%h tag=%h err=%b, required all 0", result, tag_o, range_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        send_and_capture(2'd0, pack4(0, 100, 3328, 3328), pack4(0, 200, 1, 3328), 8'h11, r, e, t, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL add_latency: %0d cycles, required 2", lat);
        end
        n_cmp++;
        if ({t, e, r} !== {8'h11, 4'b0000, pack4(0, 300, 0, 3327)}) begin
            n_err++;
            $display("FAIL add_result: tag=%h err=%b res=%h, required 11 0000 %h", t, e, r, pack4(0, 300, 0, 3327));
        end
    endtask

    task automatic test_sub();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        send_and_capture(2'd1, pack4(500, 500, 0, 10), pack4(200, 500, 1, 20), 8'h22, r, e, t, lat);
        n_cmp++;
        if ({t, e, r} !== {8'h22, 4'b0000, pack4(300, 0, 3328, 3319)} || lat !== 2) begin
            n_err++;
            $display("FAIL sub_result: lat=%0d res=%h, required lat 2 res %h", lat, r, pack4(300, 0, 3328, 3319));
        end
        // b = 0 must give back a.
        send_and_capture(2'd1, pack4(1234, 0, 3328, 1), pack4(0, 0, 0, 0), 8'h23, r, e, t, lat);
        n_cmp++;
        if (r !== pack4(1234, 0, 3328, 1)) begin
            n_err++;
            $display("FAIL sub_b_zero: res=%h, required %h", r, pack4(1234, 0, 3328, 1));
        end
    endtask

    task automatic test_neg_b();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        // Operand A is unused, so out-of-range A values must not be flagged.
        send_and_capture(2'd3, pack4(4095, 0, 3329, 5), pack4(0, 1, 3328, 1664), 8'h33, r, e, t, lat);
        n_cmp++;
        if (r !== pack4(0, 3328, 1, 1665)) begin
            n_err++;
            $display("FAIL neg_b_result: res=%h, required %h", r, pack4(0, 3328, 1, 1665));
        end
        n_cmp++;
        if (e !== 4'b0000) begin
            n_err++;
            $display("FAIL neg_b_unused_a: err=%b, required 0000", e);
        end
    endtask

    task automatic test_pass_a();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        send_and_capture(2'd2, pack4(7, 7, 7, 7),
                         pack4($urandom_range(0, 4095), 4095, 3329, $urandom_range(0, 4095)),
                         8'h44, r, e, t, lat);
        n_cmp++;
        if ({e, r} !== {4'b0000, pack4(7, 7, 7, 7)}) begin
            n_err++;
            $display("FAIL pass_a_result: err=%b res=%h, required 0000 %h", e, r, pack4(7, 7, 7, 7));
        end
    endtask

    task automatic test_range_err();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        send_and_capture(2'd0, pack4(3329, 10, 1, 3), pack4(5, 10, 2, 4), 8'h55, r, e, t, lat);
        n_cmp++;
        if (e !== 4'b0001) begin
            n_err++;
            $display("FAIL range_flag: err=%b, required 0001", e);
        end
        n_cmp++;
        if (r !== pack4(0, 20, 3, 7)) begin
            n_err++;
            $display("FAIL range_result: res=%h, required %h", r, pack4(0, 20, 3, 7));
        end
        send_and_capture(2'd0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 8'h56, r, e, t, lat);
        n_cmp++;
        if (e !== 4'b0000) begin
            n_err++;
            $display("FAIL range_not_sticky: err=%b, required 0000", e);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] a1;
        logic [BW-1:0] b1;
        logic [EW-1:0] m1;
        a1 = rand_opnd();
        b1 = rand_opnd();
        m1 = model_beat(2'd0, a1, b1, 8'd1);
        out_ready = 1'b0;
        send_beat(2'd0, a1, b1, 8'd1);
        send_beat(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 8'd2);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_drop: in_ready=%b, required 0", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            // op/tag inputs wander during the stall and must not leak in.
            op_in  = 2'($urandom_range(0, 3));
            tag_in = TW'($urandom_range(0, 255));
            n_cmp++;
            if ({out_valid, tag_o, range_err, result} !== {1'b1, m1}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d valid=%b tag=%0h res=%h, required 1 1 %h",
                         i, out_valid, tag_o, result, m1[BW-1:0]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int tg = 3; tg <= 6; tg++) begin
            send_beat(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), TW'(tg));
        end
        wait_drain("bp");
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] r;
        logic [NL-1:0] e;
        logic [TW-1:0] t;
        int lat;
        out_ready = 1'b0;
        send_beat(2'd0, rand_opnd(), rand_opnd(), 8'h21);
        send_beat(2'd1, rand_opnd(), rand_opnd(), 8'h22);
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_flush: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ghost: out_valid=%b after release, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        send_and_capture(2'd0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 8'h5A, r, e, t, lat);
        n_cmp++;
        if ({t, r} !== {8'h5A, pack4(11, 22, 33, 44)} || lat !== 2) begin
            n_err++;
            $display("FAIL rstmid_first: tag=%0h lat=%0d res=%h, required 5a 2 %h", t, lat, r, pack4(11, 22, 33, 44));
        end
    endtask

    task automatic test_random();
        int in0;
        int out0;
        bit drv_done;
        in0 = n_in;
        out0 = n_out;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    send_beat(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(),
                              TW'($urandom_range(0, 255)));
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("rand");
        n_cmp++;
        if ((n_in - in0) != 1000 || (n_out - out0) != (n_in - in0)) begin
            n_err++;
            $display("FAIL rand_count: in=%0d out=%0d, required 1000 1000", n_in - in0, n_out - out0);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_neg_b();
        test_pass_a();
        test_range_err();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
